serial_add_seq: RTL and testbench



---
 rtl/serial_add_seq.sv | 164 ++++++++++++++++
 tb/tb_serial_add_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder slice evaluated once per clock, LSB first,
// with the carry held in a flop. Operands arrive and the {carry, sum} result
// leaves over independent valid/ready handshakes. Operations never overlap.
//
//   state | meaning
//   IDLE  | waiting for an operand pair (in_ready high)
//   RUN   | one slice evaluation per edge, WIDTH edges total
//   DONE  | result held on o with out_valid high until accepted

// Single full-adder slice built from two half adders.
module serial_add_fa_slice (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    // First half adder combines the operand bits, second folds in the carry.
    always_comb begin
        s1 = x ^ y;
        c1 = x & y;
        s  = s1 ^ ci;
        c2 = s1 & ci;
        co = c1 | c2;
    end
endmodule

module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   o,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic             c_next;
    logic             s_bit;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             in_hs;
    logic             out_hs;

    serial_add_fa_slice u_slice (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_next)
    );

    // Handshake qualifiers and status decoded from the registered state.
    always_comb begin
        in_ready  = (state == IDLE) && rst_n;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    // New sum bits enter from the MSB end so bit k settles at sum[k].
    generate
        if (WIDTH == 1) begin : g_sum_w1
            always_comb sum_nx = s_bit;
        end else begin : g_sum_wn
            always_comb sum_nx = {s_bit, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_hs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand shifters, carry flop, sum shifter, bit counter and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sum_q <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sum_q <= sum_nx;
                    carry <= c_next;
                    if (last_bit) begin
                        o   <= {c_next, sum_nx};
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and exhaustive checks of the bit-serial adder at WIDTH=4 and WIDTH=1.
module tb_serial_add_seq;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] o;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [1:0] o1;
    logic       busy1;

    int n_cmp;
    int n_fail;
    int cyc;

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [4:0] exp;
        int         stall;
    } vec_t;

    vec_t tbl[6];

    serial_add_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .busy      (busy)
    );

    serial_add_seq #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .o         (o1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One complete WIDTH=4 transaction with latency, busy and handshake checks.
    task automatic do_op(input logic [3:0] x, input logic [3:0] y,
                         input logic [4:0] exp, input int stall, input string nm);
        int n;
        @(negedge clk);
        check({nm, " in_ready idle"}, in_ready, 1);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~x;
        b = ~y;
        n = 0;
        while (!out_valid && n < 20) begin
            check({nm, " busy run"}, busy, 1);
            check({nm, " in_ready run"}, in_ready, 0);
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, 4);
        check({nm, " o"}, o, exp);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({nm, " o held"}, o, exp);
            check({nm, " out_valid held"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " out_valid after hs"}, out_valid, 0);
        check({nm, " busy after hs"}, busy, 0);
        check({nm, " in_ready after hs"}, in_ready, 1);
        check({nm, " o kept"}, o, exp);
    endtask

    task automatic do_op1(input logic x, input logic y, input logic [1:0] exp, input string nm);
        int n;
        @(negedge clk);
        check({nm, " in_ready idle"}, in_ready1, 1);
        a1 = x;
        b1 = y;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        a1 = ~x;
        b1 = ~y;
        n = 0;
        while (!out_valid1 && n < 20) begin
            check({nm, " busy run"}, busy1, 1);
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, 1);
        check({nm, " o"}, o1, exp);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check({nm, " out_valid after hs"}, out_valid1, 0);
        check({nm, " in_ready after hs"}, in_ready1, 1);
    endtask

    logic [4:0] exp_q[$];
    int         got;

    initial begin
        tbl[0] = '{va: 4'd3,  vb: 4'd5,  exp: 5'd8,  stall: 0};
        tbl[1] = '{va: 4'd15, vb: 4'd15, exp: 5'd30, stall: 1};
        tbl[2] = '{va: 4'd0,  vb: 4'd0,  exp: 5'd0,  stall: 0};
        tbl[3] = '{va: 4'd15, vb: 4'd1,  exp: 5'd16, stall: 2};
        tbl[4] = '{va: 4'd10, vb: 4'd7,  exp: 5'd17, stall: 0};
        tbl[5] = '{va: 4'd8,  vb: 4'd8,  exp: 5'd16, stall: 3};

        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        got = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        a1 = '0;
        b1 = '0;

        #12;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset o", o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].va, tbl[i].vb, tbl[i].exp, tbl[i].stall, $sformatf("vec%0d", i));
        end

        // Backpressure: 9+6 held in DONE while in_valid toggles with junk.
        begin
            int n;
            @(negedge clk);
            a = 4'd9;
            b = 4'd6;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("bp latency", n, 4);
            for (int k = 0; k < 5; k++) begin
                in_valid = ~in_valid;
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                @(negedge clk);
                check("bp o", o, 15);
                check("bp out_valid", out_valid, 1);
                check("bp in_ready", in_ready, 0);
            end
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("bp exit busy", busy, 0);
            check("bp exit in_ready", in_ready, 1);
            check("bp exit out_valid", out_valid, 0);
            in_valid = 1'b0;
        end

        // Asynchronous reset two RUN edges into 7+7.
        begin
            @(negedge clk);
            a = 4'd7;
            b = 4'd7;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("rst mid o", o, 0);
            check("rst mid out_valid", out_valid, 0);
            check("rst mid busy", busy, 0);
            check("rst mid in_ready", in_ready, 0);
            @(negedge clk);
            rst_n = 1'b1;
            do_op(4'd2, 4'd3, 5'd5, 0, "post rst");
        end

        do_op1(1'b1, 1'b1, 2'b10, "w1 1+1");
        do_op1(1'b1, 1'b0, 2'b01, "w1 1+0");
        do_op1(1'b0, 1'b0, 2'b00, "w1 0+0");

        // Exhaustive, back-to-back with random output stalls.
        fork
            begin : drv
                int last_hs;
                int tries;
                last_hs = -100;
                for (int i = 0; i < 256; i++) begin
                    @(negedge clk);
                    a = 4'(i >> 4);
                    b = 4'(i);
                    in_valid = 1'b1;
                    tries = 0;
                    while (!in_ready && tries < 100) begin
                        @(negedge clk);
                        tries++;
                    end
                    if (tries >= 100) begin
                        check("exh accept timeout", tries, 0);
                        break;
                    end
                    if (last_hs >= 0) begin
                        check("exh issue interval>=6", (cyc - last_hs) >= 6, 1);
                    end
                    last_hs = cyc;
                    exp_q.push_back(5'(i >> 4) + 5'(i & 15));
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : cons
                int guard;
                guard = 0;
                while (got < 256 && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid && ($urandom_range(0, 2) != 0)) begin
                        if (exp_q.size() == 0) begin
                            check("exh unexpected result", 1, 0);
                        end else begin
                            check("exh o", o, exp_q.pop_front());
                        end
                        out_ready = 1'b1;
                        got++;
                    end else begin
                        out_ready = 1'b0;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
                check("exh result count", got, 256);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
